// File: rtl/instr_enc_pkg.sv
// Shared types and field positions for the instruction encoder/loader.
// Field layout is the fixed 32-bit word format.
package instr_enc_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_ILL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_FULL = 2'b10,
    S_ERR  = 2'b11
  } state_t;

  localparam int COND_MSB  = 31;
  localparam int OP_LSB    = 26;
  localparam int FUNCT_LSB = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int RM_LSB    = 0;
  localparam int IMM12_W   = 12;
  localparam int IMM24_W   = 24;

  typedef struct packed {
    logic [3:0]         cond;
    op_t                op;
    logic [5:0]         funct;
    logic [3:0]         rn;
    logic [3:0]         rd;
    logic [3:0]         rm;
    logic [IMM24_W-1:0] imm;
  } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational packer: decoded field bundle -> instruction word, plus illegal-op flag.
module instr_pack
  import instr_enc_pkg::*;
#(
  parameter int BITS = 32
) (
  input  instr_fields_t   f,
  output logic [BITS-1:0] word,
  output logic            ill
);

  always_comb begin
    word = '0;
    ill  = 1'b0;
    word[COND_MSB -: 4] = f.cond;
    word[OP_LSB +: 2]   = f.op;
    case (f.op)
      OP_DP, OP_MEM: begin
        word[FUNCT_LSB +: 6] = f.funct;
        word[RN_LSB +: 4]    = f.rn;
        word[RD_LSB +: 4]    = f.rd;
        // funct[5] selects the immediate form for DP; MEM always carries imm12
        if (f.op == OP_MEM || f.funct[5])
          word[IMM12_W-1:0] = f.imm[IMM12_W-1:0];
        else
          word[RM_LSB +: 4] = f.rm;
      end
      OP_BR: begin
        word[FUNCT_LSB+4 +: 2] = f.funct[5:4];
        word[IMM24_W-1:0]      = f.imm;
      end
      default: ill = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Packs field bundles into instruction words and writes them to instruction
// memory at an auto-incrementing address; stops on full or on an illegal op.
module instr_encoder_loader
  import instr_enc_pkg::*;
#(
  parameter int BITS   = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              done_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        cond,
  input  logic [1:0]        op,
  input  logic [5:0]        funct,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [23:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BITS-1:0]   mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  // Assert asynchronously, release on a clock edge two flops later.
  logic [1:0] rsync;
  logic       rst_sync_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsync <= '0;
    else        rsync <= {rsync[0], 1'b1};
  end
  assign rst_sync_n = rsync[1];

  state_t           state, state_nx;
  logic [ADDR_W-1:0] addr;
  instr_fields_t    fields;
  logic [BITS-1:0]  word;
  logic             ill;
  logic             xfer, last, do_wr, do_err;

  assign fields = '{cond: cond, op: op_t'(op), funct: funct,
                    rn: rn, rd: rd, rm: rm, imm: imm};

  instr_pack #(.BITS(BITS)) u_pack (
    .f    (fields),
    .word (word),
    .ill  (ill)
  );

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD);
  assign full     = (state == S_FULL);
  assign xfer     = in_valid & in_ready;
  assign last     = (addr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) state <= S_IDLE;
    else             state <= state_nx;
  end

  // start overrides everything, including a transfer offered in the same cycle
  always_comb begin
    state_nx = state;
    do_wr    = 1'b0;
    do_err   = 1'b0;
    if (start) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_LOAD: begin
          if (xfer && ill) begin
            do_err   = 1'b1;
            state_nx = S_ERR;
          end else begin
            do_wr = xfer;
            if (done_i)            state_nx = S_IDLE;
            else if (xfer && last) state_nx = S_FULL;
          end
        end
        S_FULL:  if (done_i) state_nx = S_IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      addr      <= '0;
      count     <= '0;
      err       <= 1'b0;
      err_addr  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= do_wr;
      if (start) begin
        addr     <= '0;
        count    <= '0;
        err      <= 1'b0;
        err_addr <= '0;
      end else begin
        if (do_wr) begin
          mem_addr  <= addr;
          mem_wdata <= word;
          count     <= count + 1'b1;
          if (!last) addr <= addr + 1'b1;
        end
        if (do_err) begin
          err      <= 1'b1;
          err_addr <= addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomised + directed bench for instr_encoder_loader with a write scoreboard.
module tb_instr_encoder_loader;
  localparam int BITS  = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, done_i = 1'b0, in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    cond = '0, rn = '0, rd = '0, rm = '0;
  logic [1:0]    op = '0;
  logic [5:0]    funct = '0;
  logic [23:0]   imm = '0;
  logic          mem_we, busy, full, err;
  logic [AW-1:0] mem_addr, err_addr;
  logic [BITS-1:0] mem_wdata;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.BITS(BITS), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .done_i(done_i),
    .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .op(op), .funct(funct), .rn(rn), .rd(rd), .rm(rm), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .busy(busy), .full(full), .err(err), .err_addr(err_addr)
  );

  int nchk = 0, npass = 0;

  typedef struct { longint a; longint d; } wr_t;
  wr_t q[$];
  wr_t mon_e;

  // reference model: mode 0 idle, 1 loading, 2 full, 3 error
  int mode = 0, maddr = 0, mcnt = 0, merr = 0, merr_addr = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    nchk++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // word value built from the field layout with plain arithmetic
  function automatic longint ref_pack(int c, int o, int f, int a, int b, int m, int i);
    longint w;
    w = longint'(c) * 268435456 + longint'(o) * 67108864;
    if (o == 0 || o == 1)
      w += longint'(f) * 1048576 + a * 65536 + b * 4096 +
           ((o == 1 || f >= 32) ? (i % 4096) : m);
    else if (o == 2)
      w += longint'(f / 16) * 16777216 + i;
    return w;
  endfunction

  task automatic step(input bit st, input bit dn, input bit v, input int c, input int o,
                      input int f, input int a, input int b, input int m, input int i);
    chk("in_ready", in_ready, mode == 1);
    start = st; done_i = dn; in_valid = v;
    cond = c[3:0]; op = o[1:0]; funct = f[5:0];
    rn = a[3:0]; rd = b[3:0]; rm = m[3:0]; imm = i[23:0];
    if (st) begin
      mode = 1; maddr = 0; mcnt = 0; merr = 0; merr_addr = 0;
    end else if (mode == 1) begin
      if (v && o == 3) begin
        mode = 3; merr = 1; merr_addr = maddr;
      end else begin
        if (v) begin
          q.push_back('{longint'(maddr), ref_pack(c, o, f, a, b, m, i)});
          mcnt++;
          if (maddr == DEPTH - 1) mode = 2;
          else maddr++;
        end
        if (dn) mode = 0;
      end
    end else if (mode == 2 && dn) begin
      mode = 0;
    end
    @(posedge clk); #1;
    start = 1'b0; done_i = 1'b0; in_valid = 1'b0;
    chk("busy", busy, mode == 1);
    chk("full", full, mode == 2);
    chk("err", err, merr);
    chk("err_addr", err_addr, merr_addr);
    chk("count", count, mcnt);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd_step(input bit st, input bit dn, input bit v, input bit allow_ill);
    int o;
    o = (allow_ill && $urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
    step(st, dn, v, int'($urandom_range(0, 15)), o, int'($urandom_range(0, 63)),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 15)), int'($urandom_range(0, 24'hFFFFFF)));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; done_i = 1'b0; in_valid = 1'b0;
    q.delete();
    mode = 0; maddr = 0; mcnt = 0; merr = 0; merr_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    idle(3);
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      if (q.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        mon_e = q.pop_front();
        chk("mem_addr", mem_addr, mon_e.a);
        chk("mem_wdata", mem_wdata, mon_e.d);
      end
    end
  end

  initial begin
    do_reset();

    // DP register, DP imm, MEM, BR back-to-back; last one fills DEPTH=4
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 'hE, 0, 'b001000, 1, 2, 3, 'hABCDEF);
    step(0, 0, 1, 'hE, 0, 'b101000, 1, 2, 9, 'h0FF);
    step(0, 0, 1, 'hE, 1, 'b011001, 3, 4, 7, 'h004);
    step(0, 0, 1, 'hE, 2, 'b100000 | int'($urandom_range(0, 15)), 5, 6, 7, 'hFFFFFE);
    rnd_step(0, 0, 1, 0);
    rnd_step(0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // six legal bundles into a four-word memory
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) rnd_step(0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1);

    // reset in the middle of loading, pending write dropped
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) rnd_step(0, 0, 1, 0);
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_step(0, 0, 1, 0);

    // illegal op as third bundle; done ignored in ERR; start recovers
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_step(0, 0, 1, 0);
    rnd_step(0, 0, 1, 0);
    step(0, 0, 1, 'h3, 3, 'h15, 1, 2, 3, 'h123456);
    rnd_step(0, 1, 1, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rnd_step(0, 0, 1, 0);

    // start + transfer + done together: transfer discarded
    rnd_step(1, 1, 1, 0);
    rnd_step(0, 0, 1, 0);
    // done with a transfer in the same cycle: still written
    rnd_step(0, 1, 1, 0);
    idle(1);

    for (int k = 0; k < 400; k++)
      rnd_step($urandom_range(0, 24) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 1) == 1, 1);

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
